// File: rtl/conv_pkg.sv
// Shared definitions for the 7x7 convolution scheduler: state encoding,
// default widths and the engine latency seen by the scheduler.
package conv_pkg;

  localparam int unsigned W_DIM_DEF  = 10;
  localparam int unsigned W_CH_DEF   = 8;
  localparam int unsigned W_BEAT_DEF = 28;
  localparam int unsigned CONV_LAT   = 4;

  // S_SETUP is the one-cycle slot in which the beat total is multiplied out.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv7x7_pos_cnt.sv
// Nested channel/column/row position counter for the scheduler; channel is
// innermost. Flags describe the beat currently held in the counters.
module conv7x7_pos_cnt #(
  parameter int unsigned W_DIM = 10,
  parameter int unsigned W_CH  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [W_DIM-1:0] w_i,
  input  logic [W_DIM-1:0] h_i,
  input  logic [W_CH-1:0]  cin_i,
  output logic [W_CH-1:0]  ch_o,
  output logic             last_o,
  output logic             row_first_o,
  output logic             frame_first_o
);

  localparam logic [W_DIM-1:0] ONE_D = W_DIM'(1);
  localparam logic [W_CH-1:0]  ONE_C = W_CH'(1);

  logic [W_CH-1:0]  ch_q, ch_d;
  logic [W_DIM-1:0] col_q, col_d;
  logic [W_DIM-1:0] row_q, row_d;
  logic             ch_wrap, col_wrap, row_wrap;

  always_comb begin
    ch_wrap  = (ch_q == cin_i - ONE_C);
    col_wrap = (col_q == w_i - ONE_D);
    row_wrap = (row_q == h_i - ONE_D);
    ch_d     = ch_q;
    col_d    = col_q;
    row_d    = row_q;
    if (clr_i) begin
      ch_d  = '0;
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (ch_wrap) begin
        ch_d = '0;
        if (col_wrap) begin
          col_d = '0;
          row_d = row_wrap ? '0 : row_q + ONE_D;
        end else begin
          col_d = col_q + ONE_D;
        end
      end else begin
        ch_d = ch_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      ch_q  <= ch_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign ch_o          = ch_q;
  assign last_o        = ch_wrap & col_wrap & row_wrap;
  assign row_first_o   = (col_q == '0) & (ch_q == '0);
  assign frame_first_o = (row_q == '0) & (col_q == '0) & (ch_q == '0);

endmodule

// File: rtl/conv7x7_sched.sv
// Frame scheduler for the 7x7 convolution engine: accepts one window per
// beat, drives engine sideband and weight address, counts results to done.
module conv7x7_sched
  import conv_pkg::*;
#(
  parameter int unsigned W_DIM  = W_DIM_DEF,
  parameter int unsigned W_CH   = W_CH_DEF,
  parameter int unsigned W_BEAT = W_BEAT_DEF
) (
  input  logic             i_sclk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [W_DIM-1:0] i_img_w,
  input  logic [W_DIM-1:0] i_img_h,
  input  logic [W_CH-1:0]  i_cin,
  input  logic             i_win_vld,
  output logic             o_win_rdy,
  output logic [W_CH-1:0]  o_waddr,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_reuse,
  output logic             o_valid,
  input  logic             i_res_valid,
  output logic             o_busy,
  output logic             o_done
);

  state_e            state_q;
  logic [W_DIM-1:0]  w_q, h_q;
  logic [W_CH-1:0]   cin_q;
  logic              empty_q;
  logic [W_BEAT-1:0] tot_q, res_cnt_q, res_cnt_d;
  logic              valid_q, vsync_q, hsync_q, reuse_q;
  logic              accept, cnt_clr, cfg_zero, res_inc;
  logic              last_beat, row_first, frame_first;
  logic [W_CH-1:0]   ch;

  assign o_win_rdy = (state_q == S_RUN);
  assign accept    = o_win_rdy & i_win_vld;
  assign cnt_clr   = (state_q == S_IDLE) & i_start;
  assign cfg_zero  = (i_img_w == '0) | (i_img_h == '0) | (i_cin == '0);

  // Saturating result count; the DRAIN exit looks at the next value so a
  // result arriving this cycle is already included.
  always_comb begin
    res_inc   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && i_res_valid
                && (res_cnt_q != tot_q);
    res_cnt_d = res_cnt_q + W_BEAT'(res_inc);
  end

  conv7x7_pos_cnt #(
    .W_DIM (W_DIM),
    .W_CH  (W_CH)
  ) u_pos_cnt (
    .clk_i         (i_sclk),
    .rst_ni        (i_rst_n),
    .clr_i         (cnt_clr),
    .en_i          (accept),
    .w_i           (w_q),
    .h_i           (h_q),
    .cin_i         (cin_q),
    .ch_o          (ch),
    .last_o        (last_beat),
    .row_first_o   (row_first),
    .frame_first_o (frame_first)
  );

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      cin_q     <= '0;
      empty_q   <= 1'b0;
      tot_q     <= '0;
      res_cnt_q <= '0;
      valid_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hsync_q   <= 1'b0;
      reuse_q   <= 1'b0;
    end else begin
      valid_q   <= accept;
      vsync_q   <= accept & frame_first;
      hsync_q   <= accept & row_first;
      reuse_q   <= accept & (ch != '0);
      res_cnt_q <= res_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            w_q       <= i_img_w;
            h_q       <= i_img_h;
            cin_q     <= i_cin;
            empty_q   <= cfg_zero;
            res_cnt_q <= '0;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          tot_q   <= W_BEAT'(w_q) * W_BEAT'(h_q) * W_BEAT'(cin_q);
          state_q <= empty_q ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (accept && last_beat) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (res_cnt_d == tot_q) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_waddr = (state_q == S_IDLE) ? '0 : ch;
  assign o_valid = valid_q;
  assign o_vsync = vsync_q;
  assign o_hsync = hsync_q;
  assign o_reuse = reuse_q;
  assign o_done  = (state_q == S_DONE);
  assign o_busy  = (state_q == S_RUN) || (state_q == S_DRAIN)
                   || (((state_q == S_SETUP) || (state_q == S_DONE)) && !empty_q);

endmodule

// File: tb/tb_conv7x7_sched.sv
// Randomised and directed bench for conv7x7_sched with a latency-4 engine
// model and a beat-index reference for position flags and weight address.
module tb_conv7x7_sched;
  import conv_pkg::*;

  localparam int unsigned WD = W_DIM_DEF;
  localparam int unsigned WC = W_CH_DEF;

  logic          i_sclk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [WD-1:0] i_img_w = '0;
  logic [WD-1:0] i_img_h = '0;
  logic [WC-1:0] i_cin = '0;
  logic          i_win_vld = 1'b0;
  logic          i_res_valid = 1'b0;
  logic          o_win_rdy, o_vsync, o_hsync, o_reuse, o_valid, o_busy, o_done;
  logic [WC-1:0] o_waddr;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  conv7x7_sched #(
    .W_DIM  (W_DIM_DEF),
    .W_CH   (W_CH_DEF),
    .W_BEAT (W_BEAT_DEF)
  ) dut (
    .i_sclk      (i_sclk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_img_w     (i_img_w),
    .i_img_h     (i_img_h),
    .i_cin       (i_cin),
    .i_win_vld   (i_win_vld),
    .o_win_rdy   (o_win_rdy),
    .o_waddr     (o_waddr),
    .o_vsync     (o_vsync),
    .o_hsync     (o_hsync),
    .o_reuse     (o_reuse),
    .o_valid     (o_valid),
    .i_res_valid (i_res_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_sclk = ~i_sclk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_sclk);
    #1;
  endtask

  // Beat b of a frame, row-major positions with channel innermost.
  function automatic void exp_beat(input int b, input int w, input int cin,
                                   output int ch, output bit vs, output bit hs, output bit ru);
    int c;
    ch = b % cin;
    c  = (b / cin) % w;
    vs = (b == 0);
    hs = (c == 0) && (ch == 0);
    ru = (ch != 0);
  endfunction

  function automatic longint outs_vec();
    return {o_win_rdy, o_vsync, o_hsync, o_reuse, o_valid, o_busy, o_done, o_waddr};
  endfunction

  task automatic reset_mid();
    #2;
    i_rst_n     = 1'b0;
    i_win_vld   = 1'b0;
    i_res_valid = 1'b0;
    i_start     = 1'b0;
    #1;
    check_eq("rst_outputs_zero", outs_vec(), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_hold_quiet", outs_vec(), 0);
    end
    i_rst_n = 1'b1;
    step();
    check_eq("rst_release_idle", {o_done, o_busy, o_win_rdy}, 0);
  endtask

  // mode: 0 = window always valid, 1 = valid pattern 1,0,0,1, 2 = random
  task automatic run_frame(input int w, input int h, input int cin, input int mode,
                           input int restart_at, input int rst_after);
    int total, nacc, nval, nres, ndone, cyc, budget, last_res, done_cyc, p, ech;
    bit acc_prev, empty, aborted, res, evs, ehs, eru;
    logic [CONV_LAT-1:0] eng;
    total = w * h * cin;
    empty = (total == 0);
    nacc = 0; nval = 0; nres = 0; ndone = 0; cyc = 0; p = 0;
    last_res = -10; done_cyc = -1; acc_prev = 0; aborted = 0; eng = '0;
    budget = total * 8 + 40;
    i_img_w = WD'(w);
    i_img_h = WD'(h);
    i_cin   = WC'(cin);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_img_w = WD'($urandom);
    i_img_h = WD'($urandom);
    i_cin   = WC'($urandom);
    while (ndone == 0 && cyc < budget && !aborted) begin
      if (rst_after > 0 && nval == rst_after) begin
        reset_mid();
        aborted = 1;
      end else begin
        check_eq("valid_follows_accept", o_valid, acc_prev);
        if (o_valid) begin
          exp_beat(nval, w, cin, ech, evs, ehs, eru);
          check_eq($sformatf("vsync[%0d]", nval), o_vsync, evs);
          check_eq($sformatf("hsync[%0d]", nval), o_hsync, ehs);
          check_eq($sformatf("reuse[%0d]", nval), o_reuse, eru);
          nval++;
        end else begin
          check_eq("sideband_idle", {o_vsync, o_hsync, o_reuse}, 0);
        end
        if (o_done) begin
          ndone++;
          done_cyc = cyc;
          check_eq("done_result_count", nres, total);
          check_eq("busy_at_done", o_busy, !empty);
          if (!empty) check_eq("done_after_last_result", cyc - last_res, 1);
        end
        if (empty) check_eq("empty_quiet", {o_busy, o_win_rdy, o_valid}, 0);
        res = eng[CONV_LAT-1];
        eng = {eng[CONV_LAT-2:0], o_valid};
        i_res_valid = res;
        if (res) begin
          nres++;
          last_res = cyc;
        end
        case (mode)
          0:       i_win_vld = 1'b1;
          1:       i_win_vld = (p % 4 == 0) || (p % 4 == 3);
          default: i_win_vld = ($urandom_range(0, 3) != 0);
        endcase
        p++;
        if (o_win_rdy) begin
          exp_beat(nacc, w, cin, ech, evs, ehs, eru);
          check_eq($sformatf("waddr[%0d]", nacc), o_waddr, ech);
          check_eq("busy_in_run", o_busy, 1);
        end
        acc_prev = o_win_rdy & i_win_vld;
        if (acc_prev) nacc++;
        if (restart_at >= 0 && nacc == restart_at && o_win_rdy) begin
          i_start = 1'b1;
          i_img_w = WD'(2);
          i_img_h = WD'(2);
          i_cin   = WC'(1);
        end else begin
          i_start = 1'b0;
        end
        step();
        cyc++;
      end
    end
    i_win_vld   = 1'b0;
    i_start     = 1'b0;
    i_res_valid = 1'b0;
    if (!aborted) begin
      check_eq("done_seen", ndone, 1);
      check_eq("beats_issued", nval, total);
      check_eq("beats_accepted", nacc, total);
      if (empty) check_eq("empty_done_latency", done_cyc, 1);
      for (int i = 0; i < 6; i++) begin
        check_eq("post_frame_quiet", {o_done, o_valid, o_busy, o_win_rdy}, 0);
        check_eq("post_frame_waddr", o_waddr, 0);
        i_res_valid = ($urandom_range(0, 1) == 1);
        step();
      end
      i_res_valid = 1'b0;
    end
  endtask

  initial begin
    #3;
    check_eq("reset_async_outputs", outs_vec(), 0);
    step();
    step();
    check_eq("reset_hold_outputs", outs_vec(), 0);
    i_rst_n = 1'b1;
    step();
    check_eq("after_release_idle", outs_vec(), 0);

    run_frame(3, 2, 2, 0, -1, 0);
    run_frame(3, 2, 2, 1, -1, 0);
    run_frame(3, 2, 2, 0, 3, 0);
    run_frame(4, 4, 0, 0, -1, 0);
    run_frame(1, 1, 1, 0, -1, 0);
    run_frame(3, 2, 2, 0, -1, 5);
    run_frame(3, 2, 2, 0, -1, 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 4)), 2, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv7x7_sched.md
Name: conv7x7_sched

Overview:
- Frame scheduler that sequences the 7x7 convolution engine over one feature map.
- Walks output positions row-major. At each position it iterates over every input channel.
- Accepts one 7x7 window per beat from the line-buffer window source. Drives the engine sideband (vsync/hsync/reuse/valid) and the weight-ROM address.
- Counts engine results to report frame completion. Sits between the window generator, the weight ROM and the conv engine.

Parameters:
- W_DIM, 10, width of image width/height config and of row/col counters
- W_CH, 8, width of input-channel count config and of the weight address
- W_BEAT, 28, width of beat/result counters (must be >= 2*W_DIM+W_CH)

Ports:
- i_sclk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; config sampled on the same cycle
- i_img_w  in  W_DIM  output positions per row
- i_img_h  in  W_DIM  rows per frame
- i_cin  in  W_CH  input channels per position
- i_win_vld  in  1  window source has a window available
- o_win_rdy  out  1  scheduler accepts a window this cycle
- o_waddr  out  W_CH  weight-ROM address (channel index of the accepted beat)
- o_vsync  out  1  to engine: first beat of frame
- o_hsync  out  1  to engine: first beat of a row
- o_reuse  out  1  to engine: beat accumulates onto the previous channel partial sum
- o_valid  out  1  to engine: window beat valid
- i_res_valid  in  1  engine output valid
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = IDLE; all counters 0.
- FSM states and transitions:
  - IDLE, on i_start:
    - If any of i_img_w, i_img_h, i_cin is 0: go to DONE. No beats are issued.
    - Otherwise latch the config, clear counters and go to RUN.
  - RUN: o_win_rdy=1. A beat is accepted when i_win_vld & o_win_rdy.
    - On each accepted beat, counters advance: ch innermost, then col, then row.
    - On the acceptance of the last beat (row=h-1, col=w-1, ch=cin-1), go to DRAIN. o_win_rdy is 0 from the next cycle.
  - DRAIN: o_win_rdy=0. Go to DONE when the result count equals the total beats (w*h*cin). This is checked including an i_res_valid arriving in the current cycle.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- o_busy = 1 in RUN and DRAIN, and in DONE only for a non-empty frame.
- i_start outside IDLE is ignored. The config inputs are don't-care outside the start cycle.
- o_waddr is combinational from the registered ch counter. It holds the current beat's channel while the beat waits for acceptance. It is 0 in IDLE.
- Sideband outputs are registered and assert in the cycle after acceptance, aligned with the synchronous ROM read data for o_waddr:
  - o_valid = 1 for each accepted beat, else 0.
  - o_vsync = 1 when row=0, col=0, ch=0.
  - o_hsync = 1 when col=0, ch=0.
  - o_reuse = 1 when ch != 0.
  - vsync/hsync/reuse are 0 whenever o_valid=0.
- Stall: i_win_vld=0 in RUN holds all counters and deasserts o_valid. There is no bubble penalty; back-to-back beats run at 1/cycle.
- Result counter: increments on every i_res_valid in RUN or DRAIN. Results may arrive while still in RUN because the engine latency is 4. i_res_valid in IDLE/DONE is ignored. The counter saturates at the total and never wraps.
- Totals are computed once at start (registered product, W_BEAT bits). The product multiplier may be pipelined by up to 2 cycles, in which case RUN entry is delayed by the same amount and o_busy asserts on entry to that delay.
- Reset mid-frame returns to IDLE immediately. No o_done is generated and in-flight engine results are discarded.

Decomposition:
- Shared package conv_pkg: FSM state encoding (IDLE, RUN, DRAIN, DONE), the W_DIM/W_CH/W_BEAT defaults, and the engine latency constant CONV_LAT=4 (used by the bench).
- One sub-module, conv7x7_pos_cnt: nested ch/col/row counter with an enable, last-beat flag and first-of-row/frame flags.

Test Plan:
- w=3, h=2, cin=2, i_win_vld always 1, engine model with latency 4:
  - 12 consecutive o_valid beats.
  - o_vsync on beat 0; o_hsync on beats 0 and 6; o_reuse on beats 1,3,5,7,9,11.
  - o_waddr sequence 0,1,0,1,...
  - o_done exactly 1 cycle after the 12th i_res_valid.
- Same config with i_win_vld toggling 1,0,0,1:
  - o_waddr is held while stalled.
  - Beat order and flags are identical to the first test.
  - No o_valid in stall cycles.
  - Total 12 beats.
- i_start pulsed again mid-RUN with different config: ignored; the frame completes with the original 12 beats and one o_done.
- i_cin=0 (w=4, h=4): no o_valid, o_win_rdy stays 0, o_done pulses 2 cycles after i_start, o_busy never 1.
- w=1, h=1, cin=1: a single beat carrying vsync=hsync=1 and reuse=0; o_done after the single result.
- Reset asserted after the 5th beat of a 3x2x2 frame:
  - All outputs 0 immediately; FSM in IDLE, no o_done.
  - A following start runs a full clean 12-beat frame with o_vsync on beat 0.
